// File: rtl/myproject_axi_div_pkg.sv
// Shared widths, FSM states and saturation bounds for the sequential signed divider.
package myproject_axi_div_pkg;

   localparam int unsigned DividendW = 21;
   localparam int unsigned DivisorW  = 6;
   localparam int unsigned QuotientW = 16;
   localparam int unsigned MagW      = 22;
   localparam int unsigned CntW      = 5;

   localparam logic [CntW-1:0] StepsM1 = CntW'(DividendW - 1);

   localparam logic signed [QuotientW-1:0] QMAX = 16'sh7FFF;
   localparam logic signed [QuotientW-1:0] QMIN = 16'sh8000;

   // Largest quotient magnitudes representable for each result sign
   localparam logic [DividendW-1:0] QMagPos = 21'd32767;
   localparam logic [DividendW-1:0] QMagNeg = 21'd32768;

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StDone
   } div_state_e;

endpackage

// File: rtl/myproject_axi_sdiv_step.sv
// One restoring division step: shift in a dividend bit, trial-subtract the divisor.
module myproject_axi_sdiv_step
   import myproject_axi_div_pkg::*;
#(
   parameter int unsigned Width = MagW
) (
   input  logic [Width-1:0] i_rem,
   input  logic             i_bit,
   input  logic [Width-1:0] i_den,
   output logic [Width-1:0] o_rem,
   output logic             o_qbit
);

   logic [Width:0] w_shift;
   logic [Width:0] w_diff;

   always_comb begin
      w_shift = {i_rem, i_bit};
      w_diff  = w_shift - {1'b0, i_den};
      o_qbit  = (w_shift >= {1'b0, i_den});
      o_rem   = o_qbit ? Width'(w_diff) : Width'(w_shift);
   end

endmodule

// File: rtl/myproject_axi_sdiv_21s_6s_16_seq.sv
// Sequential signed 21/6 divider: 21 restoring steps, then sign and saturation fix-up.
module myproject_axi_sdiv_21s_6s_16_seq
   import myproject_axi_div_pkg::*;
#(
   parameter logic [31:0] ID             = 32'd1,
   parameter int unsigned DIVIDEND_WIDTH = 21,
   parameter int unsigned DIVISOR_WIDTH  = 6,
   parameter int unsigned QUOTIENT_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ce,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DIVIDEND_WIDTH-1:0] din0,
   input  logic [DIVISOR_WIDTH-1:0]  din1,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [QUOTIENT_WIDTH-1:0] quot,
   output logic [DIVISOR_WIDTH-1:0]  rem,
   output logic                      dbz,
   output logic                      ovf
);

   if (DIVIDEND_WIDTH != DividendW || DIVISOR_WIDTH != DivisorW ||
       QUOTIENT_WIDTH != QuotientW || $bits(ID) != 32) begin : g_width_chk
      $error("myproject_axi_sdiv_21s_6s_16_seq supports only the 21/6/16 configuration");
   end

   div_state_e r_state;
   div_state_e w_state_nxt;

   logic [CntW-1:0]      r_cnt;
   logic [DividendW-1:0] r_num;
   logic [MagW-1:0]      r_prem;
   logic [MagW-1:0]      r_den;
   logic                 r_neg_q;
   logic                 r_neg_r;
   logic                 r_zero;
   logic [QuotientW-1:0] r_quot;
   logic [DivisorW-1:0]  r_rem;
   logic                 r_dbz;
   logic                 r_ovf;

   logic [MagW-1:0]      w_a_sext;
   logic [MagW-1:0]      w_b_sext;
   logic [MagW-1:0]      w_a_mag;
   logic [MagW-1:0]      w_b_mag;
   logic [MagW-1:0]      w_step_rem;
   logic                 w_qbit;
   logic [DividendW-1:0] w_q_mag;
   logic [DivisorW-1:0]  w_r_mag;
   logic [QuotientW-1:0] w_quot_fix;
   logic [DivisorW-1:0]  w_rem_fix;
   logic                 w_ovf_fix;

   // Magnitudes are taken at 22 bits so that |-2^20| is representable
   always_comb begin
      w_a_sext = {din0[DividendW-1], din0};
      w_b_sext = {{(MagW - DivisorW){din1[DivisorW-1]}}, din1};
      w_a_mag  = din0[DividendW-1] ? (MagW'(0) - w_a_sext) : w_a_sext;
      w_b_mag  = din1[DivisorW-1] ? (MagW'(0) - w_b_sext) : w_b_sext;
   end

   myproject_axi_sdiv_step #(
      .Width (MagW)
   ) u_step (
      .i_rem  (r_prem),
      .i_bit  (r_num[DividendW-1]),
      .i_den  (r_den),
      .o_rem  (w_step_rem),
      .o_qbit (w_qbit)
   );

   always_comb begin
      w_q_mag    = {r_num[DividendW-2:0], w_qbit};
      w_r_mag    = DivisorW'(w_step_rem);
      w_quot_fix = '0;
      w_rem_fix  = '0;
      w_ovf_fix  = 1'b0;
      if (r_zero) begin
         w_quot_fix = r_neg_r ? QMIN : QMAX;
      end else if (r_neg_q && (w_q_mag > QMagNeg)) begin
         w_quot_fix = QMIN;
         w_ovf_fix  = 1'b1;
      end else if (!r_neg_q && (w_q_mag > QMagPos)) begin
         w_quot_fix = QMAX;
         w_ovf_fix  = 1'b1;
      end else begin
         w_quot_fix = r_neg_q ? QuotientW'(DividendW'(0) - w_q_mag) : QuotientW'(w_q_mag);
         w_rem_fix  = r_neg_r ? (DivisorW'(0) - w_r_mag) : w_r_mag;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StIdle:  if (in_valid)      w_state_nxt = StCalc;
         StCalc:  if (r_cnt == '0)   w_state_nxt = StDone;
         StDone:  if (out_ready)     w_state_nxt = StIdle;
         default:                    w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= StIdle;
      end else if (ce) begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt   <= '0;
         r_num   <= '0;
         r_prem  <= '0;
         r_den   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_zero  <= 1'b0;
         r_quot  <= '0;
         r_rem   <= '0;
         r_dbz   <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (ce) begin
         case (r_state)
            StIdle: begin
               if (in_valid) begin
                  r_num   <= DividendW'(w_a_mag);
                  r_den   <= w_b_mag;
                  r_prem  <= '0;
                  r_cnt   <= StepsM1;
                  r_neg_q <= din0[DividendW-1] ^ din1[DivisorW-1];
                  r_neg_r <= din0[DividendW-1];
                  r_zero  <= (din1 == '0);
               end
            end
            StCalc: begin
               r_num  <= {r_num[DividendW-2:0], w_qbit};
               r_prem <= w_step_rem;
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  r_quot <= w_quot_fix;
                  r_rem  <= w_rem_fix;
                  r_dbz  <= r_zero;
                  r_ovf  <= w_ovf_fix;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == StIdle);
   assign out_valid = (r_state == StDone);
   assign quot      = r_quot;
   assign rem       = r_rem;
   assign dbz       = r_dbz;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_myproject_axi_sdiv_21s_6s_16_seq.sv
// Directed self-checking bench for the sequential signed divider.
module tb_myproject_axi_sdiv_21s_6s_16_seq;

   logic        clk;
   logic        reset;
   logic        ce;
   logic        in_valid;
   logic        in_ready;
   logic [20:0] din0;
   logic [5:0]  din1;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] quot;
   logic [5:0]  rem;
   logic        dbz;
   logic        ovf;

   int n_total;
   int n_bad;

   myproject_axi_sdiv_21s_6s_16_seq #(
      .ID             (32'd1),
      .DIVIDEND_WIDTH (21),
      .DIVISOR_WIDTH  (6),
      .QUOTIENT_WIDTH (16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ce        (ce),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .din0      (din0),
      .din1      (din1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quot      (quot),
      .rem       (rem),
      .dbz       (dbz),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issues one operation and checks latency, results and hand-off.
   task automatic run_op(input string name, input int a, input int b, input int eq,
                         input int er, input logic edbz, input logic eovf,
                         input int exp_lat, input int drop_at, input bit hold);
      int lat;
      lat = 100;
      @(negedge clk);
      din0     = a[20:0];
      din1     = b[5:0];
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (hold) begin
         in_valid = 1'b1;
         din0     = 21'd12345;
         din1     = 6'd3;
      end
      for (int n = 1; n <= 100; n++) begin
         ce = (drop_at >= 0 && n > drop_at && n <= drop_at + 3) ? 1'b0 : 1'b1;
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = n;
            break;
         end
      end
      ce = 1'b1;
      check({name, ".latency"}, 32'(lat), 32'(exp_lat));
      if (hold) begin
         for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check({name, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({name, ".hold_ready"}, {31'd0, in_ready}, 32'd0);
            check({name, ".hold_quot"}, {16'd0, quot}, {16'd0, eq[15:0]});
            check({name, ".hold_rem"}, {26'd0, rem}, {26'd0, er[5:0]});
         end
         in_valid = 1'b0;
      end
      check({name, ".quot"}, {16'd0, quot}, {16'd0, eq[15:0]});
      check({name, ".rem"}, {26'd0, rem}, {26'd0, er[5:0]});
      check({name, ".dbz"}, {31'd0, dbz}, {31'd0, edbz});
      check({name, ".ovf"}, {31'd0, ovf}, {31'd0, eovf});
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({name, ".drain_valid"}, {31'd0, out_valid}, 32'd0);
      check({name, ".drain_ready"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      bit seen;
      n_total   = 0;
      n_bad     = 0;
      clk       = 1'b0;
      reset     = 1'b1;
      ce        = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      din0      = '0;
      din1      = '0;

      #12;
      check("rst.in_ready", {31'd0, in_ready}, 32'd1);
      check("rst.out_valid", {31'd0, out_valid}, 32'd0);
      check("rst.quot", {16'd0, quot}, 32'd0);
      check("rst.rem", {26'd0, rem}, 32'd0);
      check("rst.dbz", {31'd0, dbz}, 32'd0);
      check("rst.ovf", {31'd0, ovf}, 32'd0);

      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("post_rst.in_ready", {31'd0, in_ready}, 32'd1);
      check("post_rst.out_valid", {31'd0, out_valid}, 32'd0);

      run_op("p1000_7",   1000,     7,    142,  6, 1'b0, 1'b0, 21, -1, 1'b0);
      run_op("n1000_7",   -1000,    7,   -142, -6, 1'b0, 1'b0, 21, -1, 1'b0);
      run_op("p1000_n7",  1000,    -7,   -142,  6, 1'b0, 1'b0, 21, -1, 1'b0);
      run_op("p1000_0",   1000,     0,  32767,  0, 1'b1, 1'b0, 21, -1, 1'b0);
      run_op("n5_0",      -5,       0, -32768,  0, 1'b1, 1'b0, 21, -1, 1'b0);
      run_op("min_1",     -1048576, 1, -32768,  0, 1'b0, 1'b1, 21, -1, 1'b0);
      run_op("max_n32",   1048575, -32, -32767, 31, 1'b0, 1'b0, 21, -1, 1'b0);
      run_op("p32768_n1", 32768,   -1, -32768,  0, 1'b0, 1'b0, 21, -1, 1'b0);
      run_op("p32768_1",  32768,    1,  32767,  0, 1'b0, 1'b1, 21, -1, 1'b0);
      run_op("n100_n9",   -100,    -9,     11, -1, 1'b0, 1'b0, 21, -1, 1'b0);
      run_op("hold",      1000,     7,    142,  6, 1'b0, 1'b0, 21, -1, 1'b1);
      run_op("ce_drop",   -1000,    7,   -142, -6, 1'b0, 1'b0, 24,  5, 1'b0);
      run_op("pre_abort", -1048576, 1, -32768,  0, 1'b0, 1'b1, 21, -1, 1'b0);

      // Abort an operation midway through CALC with an asynchronous reset
      @(negedge clk);
      din0     = 21'd500;
      din1     = 6'd3;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("abort.out_valid", {31'd0, out_valid}, 32'd0);
      check("abort.in_ready", {31'd0, in_ready}, 32'd1);
      check("abort.quot", {16'd0, quot}, 32'd0);
      check("abort.rem", {26'd0, rem}, 32'd0);
      check("abort.dbz", {31'd0, dbz}, 32'd0);
      check("abort.ovf", {31'd0, ovf}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      seen  = 1'b0;
      for (int n = 0; n < 30; n++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      check("abort.no_result", {31'd0, seen}, 32'd0);

      run_op("p300_n7", 300, -7, -42, 6, 1'b0, 1'b0, 21, -1, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
